// File: rtl/md5_search_dispatcher_if.sv
// Charset RAM and MD5 core-array bundle between the search dispatcher (master) and its attached cores/RAM (slave).
// Purely wiring: no latency, flow control is core_ready/core_valid per core.
interface md5_search_dispatcher_if #(
  parameter int NUM_CORES = 2,
  parameter int CHARS     = 8,
  parameter int IDX_BITS  = 6
);
  logic [IDX_BITS-1:0]      cs_addr;
  logic [7:0]               cs_data;
  logic [8*CHARS-1:0]       core_msg;
  logic [7:0]               core_width;
  logic [NUM_CORES-1:0]     core_valid;
  logic [NUM_CORES-1:0]     core_ready;
  logic [128*NUM_CORES-1:0] core_digest;
  logic [NUM_CORES-1:0]     core_dvalid;

  modport master (
    output cs_addr, core_msg, core_width, core_valid,
    input  cs_data, core_ready, core_digest, core_dvalid
  );

  modport slave (
    input  cs_addr, core_msg, core_width, core_valid,
    output cs_data, core_ready, core_digest, core_dvalid
  );
endinterface

// File: rtl/md5_search_dispatcher.sv
// Brute-force candidate walker: expands each index via the charset RAM (CHARS+1 cycles), loads the lowest free core,
// and checks returned digests; stalls in DISPATCH while no core is ready, first matching digest wins.
module md5_search_dispatcher #(
  parameter int NUM_CORES = 2,
  parameter int CHARS     = 8,
  parameter int IDX_BITS  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CHARS*IDX_BITS-1:0] start_index,
  input  logic [127:0]              target,
  md5_search_dispatcher_if.master   bus,
  output logic                      busy,
  output logic                      found,
  output logic [8*CHARS-1:0]        found_msg,
  output logic [2:0]                found_core,
  output logic                      exhausted
);
  localparam int CW = CHARS*IDX_BITS;
  localparam int MW = 8*CHARS;
  localparam int FW = $clog2(CHARS+1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DISPATCH, S_DRAIN, S_FOUND, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]        counter;
  logic [127:0]         target_q;
  logic [MW-1:0]        buffer;
  logic [MW-1:0]        cand [NUM_CORES];
  logic [NUM_CORES-1:0] pending;
  logic [FW-1:0]        fetch_cnt;
  logic [IDX_BITS-1:0]  cs_addr_q;

  logic                 active;
  logic [NUM_CORES-1:0] retire;
  logic [NUM_CORES-1:0] hit;
  logic                 match;
  logic [2:0]           match_idx;
  logic [MW-1:0]        found_msg_nxt;
  logic [NUM_CORES-1:0] free;
  logic                 any_free;
  logic [NUM_CORES-1:0] sel_oh;
  logic                 fetch_en;
  logic [IDX_BITS-1:0]  fetch_addr;
  logic                 dispatch;
  logic                 start_acc;

  // Digest checking and core selection
  always_comb begin
    active        = (state == S_FETCH) || (state == S_DISPATCH) || (state == S_DRAIN);
    retire        = active ? (bus.core_dvalid & pending) : '0;
    hit           = '0;
    match         = 1'b0;
    match_idx     = '0;
    found_msg_nxt = '0;
    free          = bus.core_ready & ~pending;
    any_free      = 1'b0;
    sel_oh        = '0;
    fetch_addr    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      hit[i] = retire[i] && (bus.core_digest[128*i +: 128] == target_q);
    end
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (hit[i]) begin
        match     = 1'b1;
        match_idx = 3'(i);
      end
      if (free[i]) begin
        any_free  = 1'b1;
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (match_idx == 3'(i)) found_msg_nxt = cand[i];
    end
    fetch_en = (state == S_FETCH) && (fetch_cnt < FW'(CHARS));
    for (int k = 0; k < CHARS; k++) begin
      if (fetch_cnt == FW'(k)) fetch_addr = counter[IDX_BITS*k +: IDX_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dispatch  = 1'b0;
    start_acc = 1'b0;
    case (state)
      S_IDLE, S_FOUND, S_DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (match)                        state_nxt = S_FOUND;
        else if (fetch_cnt == FW'(CHARS)) state_nxt = S_DISPATCH;
      end
      S_DISPATCH: begin
        // A match in the same cycle suppresses the load
        if (match) state_nxt = S_FOUND;
        else if (any_free) begin
          dispatch  = 1'b1;
          state_nxt = (&counter) ? S_DRAIN : S_FETCH;
        end
      end
      S_DRAIN: begin
        if (match)              state_nxt = S_FOUND;
        else if (pending == '0) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter    <= '0;
      target_q   <= '0;
      buffer     <= '0;
      pending    <= '0;
      fetch_cnt  <= '0;
      cs_addr_q  <= '0;
      found      <= 1'b0;
      found_msg  <= '0;
      found_core <= '0;
      exhausted  <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) cand[i] <= '0;
    end else begin
      pending <= (pending & ~retire) | (dispatch ? sel_oh : '0);
      for (int i = 0; i < NUM_CORES; i++) begin
        if (dispatch && sel_oh[i]) cand[i] <= buffer;
      end
      if (start_acc) begin
        counter   <= start_index;
        target_q  <= target;
        found     <= 1'b0;
        exhausted <= 1'b0;
        fetch_cnt <= '0;
        pending   <= '0;
      end
      if (state == S_FETCH) begin
        if (fetch_en) cs_addr_q <= fetch_addr;
        // RAM data lags the address by one cycle, so cycle c captures char c-1
        for (int k = 0; k < CHARS; k++) begin
          if (fetch_cnt == FW'(k+1)) buffer[MW-1-8*k -: 8] <= bus.cs_data;
        end
        fetch_cnt <= (fetch_cnt == FW'(CHARS)) ? '0 : fetch_cnt + 1'b1;
      end
      if (dispatch && !(&counter)) counter <= counter + 1'b1;
      if (match) begin
        found      <= 1'b1;
        found_msg  <= found_msg_nxt;
        found_core <= match_idx;
      end
      if ((state == S_DRAIN) && (pending == '0) && !match) exhausted <= 1'b1;
    end
  end

  assign bus.cs_addr    = fetch_en ? fetch_addr : cs_addr_q;
  assign bus.core_msg   = buffer;
  assign bus.core_width = 8'(MW);
  assign bus.core_valid = dispatch ? sel_oh : '0;
  assign busy           = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_md5_search_dispatcher.sv
// Bench for md5_search_dispatcher: charset RAM, latency-configurable stub MD5 cores, directed and randomized searches.
module tb_md5_search_dispatcher;
  localparam int NC = 2;
  localparam int CH = 2;
  localparam int IB = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   start_index = '0;
  logic [127:0] target = '0;
  logic         busy, found, exhausted;
  logic [15:0]  found_msg;
  logic [2:0]   found_core;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  md5_search_dispatcher_if #(.NUM_CORES(NC), .CHARS(CH), .IDX_BITS(IB)) bus ();

  md5_search_dispatcher #(.NUM_CORES(NC), .CHARS(CH), .IDX_BITS(IB)) dut (
    .clk(clk), .reset(reset), .start(start), .start_index(start_index), .target(target),
    .bus(bus), .busy(busy), .found(found), .found_msg(found_msg),
    .found_core(found_core), .exhausted(exhausted)
  );

  localparam logic [127:0] NO_HIT = {128{1'b1}};

  function automatic logic [127:0] stub(input logic [15:0] m);
    return {m ^ 16'h1234, m, ~m, m + 16'h0101, m ^ 16'h5A5A, 16'hC0DE, m, 16'h0F0F};
  endfunction

  // Index digit c (2 bits each, LSB first) selects 'a'+digit; char 0 is the leading byte
  function automatic logic [15:0] msg_of(input int k);
    logic [7:0] c0, c1;
    c0 = 8'(8'h61 + (k & 3));
    c1 = 8'(8'h61 + ((k >> 2) & 3));
    return {c0, c1};
  endfunction

  logic [7:0] charset [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
  always @(posedge clk) bus.cs_data <= charset[bus.cs_addr];

  logic [NC-1:0] cm_busy = '0;
  logic [NC-1:0] hold = '0;
  logic [NC-1:0] dis = '0;
  int            cm_cnt [NC];
  logic [15:0]   cm_msg [NC];
  int            lat_lo = 5, lat_hi = 5;
  int            proto_err = 0;
  logic [15:0]   log_msg [$];
  int            log_core [$];

  assign bus.core_ready = ~cm_busy & ~dis;

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      bus.core_dvalid[i] <= 1'b0;
      if (bus.core_valid[i] === 1'b1 && !bus.core_ready[i]) proto_err++;
      if (!cm_busy[i]) begin
        if (bus.core_valid[i] === 1'b1) begin
          cm_busy[i] <= 1'b1;
          cm_cnt[i]  <= int'($urandom_range(lat_hi, lat_lo));
          cm_msg[i]  <= bus.core_msg;
        end
      end else if (cm_cnt[i] > 1) begin
        cm_cnt[i] <= cm_cnt[i] - 1;
      end else if (!hold[i]) begin
        bus.core_dvalid[i]             <= 1'b1;
        bus.core_digest[128*i +: 128]  <= stub(cm_msg[i]);
        cm_busy[i]                     <= 1'b0;
      end
    end
    if (!reset && bus.core_valid !== '0) begin
      if ($countones(bus.core_valid) != 1) proto_err++;
      for (int i = 0; i < NC; i++) begin
        if (bus.core_valid[i] === 1'b1) begin
          log_msg.push_back(bus.core_msg);
          log_core.push_back(i);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] s, input logic [127:0] t);
    tick();
    start = 1'b1;
    start_index = s;
    target = t;
    log_msg.delete();
    log_core.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (found === 1'b1 || exhausted === 1'b1) done = 1;
    end
    check({tag, "_timeout"}, 128'(done), 128'd1);
  endtask

  task automatic check_order(input string tag, input int s);
    int bad = 0;
    foreach (log_msg[j]) if (log_msg[j] !== msg_of(s + j)) bad++;
    check(tag, 128'(bad), 128'd0);
  endtask

  function automatic int core_of(input logic [15:0] m);
    int r = -1;
    foreach (log_msg[j]) if (log_msg[j] == m) r = log_core[j];
    return r;
  endfunction

  initial begin
    int bad;
    int s, k, mode, n0, n1;
    logic [15:0] exp_msg;

    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset: nothing happens without start
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0 || bus.core_valid !== '0) bad++;
    end
    check("idle_100", 128'(bad), 128'd0);
    check("rst_cs_addr", 128'(bus.cs_addr), 128'd0);
    check("rst_core_msg", 128'(bus.core_msg), 128'd0);
    check("rst_found_msg", 128'(found_msg), 128'd0);
    check("rst_found_core", 128'(found_core), 128'd0);
    check("core_width", 128'(bus.core_width), 128'd16);

    // Match on the third candidate
    launch(4'h0, stub(msg_of(2)));
    wait_done("t2");
    check("t2_found", 128'(found), 128'd1);
    check("t2_exh", 128'(exhausted), 128'd0);
    check("t2_found_msg", 128'(found_msg), 128'("ca"));
    check("t2_found_core", 128'(found_core), 128'(core_of(16'("ca"))));
    n0 = 0; n1 = 0;
    foreach (log_core[j]) if (log_core[j] == 0) n0++; else n1++;
    check("t2_both_cores", 128'((n0 > 0) && (n1 > 0)), 128'd1);
    check_order("t2_order", 0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.core_valid !== '0 || found_msg !== msg_of(2) || found !== 1'b1) bad++;
    end
    check("t2_hold", 128'(bad), 128'd0);

    // Last two indices, no match
    launch(4'hE, NO_HIT);
    wait_done("t3");
    check("t3_exh", 128'(exhausted), 128'd1);
    check("t3_found", 128'(found), 128'd0);
    check("t3_busy", 128'(busy), 128'd0);
    check("t3_count", 128'(log_msg.size()), 128'd2);
    check("t3_first", 128'(log_msg.size() > 0 ? log_msg[0] : 16'h0), 128'("cd"));
    check_order("t3_order", 14);

    // Simultaneous digests, only core1 matches
    hold = 2'b11;
    launch(4'h0, stub(msg_of(1)));
    repeat (20) tick();
    hold = 2'b00;
    wait_done("t4");
    check("t4_found", 128'(found), 128'd1);
    check("t4_found_core", 128'(found_core), 128'd1);
    check("t4_found_msg", 128'(found_msg), 128'("ba"));
    check("t4_count", 128'(log_msg.size()), 128'd2);

    // Reset while dispatching; the pending core's matching digest must be ignored
    launch(4'h0, stub(msg_of(0)));
    bad = 1;
    for (int c = 0; c < 50 && bad == 1; c++) begin
      @(negedge clk);
      if (bus.core_valid !== '0) bad = 0;
    end
    check("t5_saw_dispatch", 128'(bad), 128'd0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (found !== 1'b0 || busy !== 1'b0 || exhausted !== 1'b0 || bus.core_valid !== '0 ||
          bus.cs_addr !== '0 || found_msg !== '0 || found_core !== '0) bad++;
    end
    check("t5_quiet", 128'(bad), 128'd0);
    check("t5_found", 128'(found), 128'd0);

    // Core0 never ready
    dis = 2'b01;
    launch(4'hC, NO_HIT);
    wait_done("t6");
    n0 = 0;
    foreach (log_core[j]) if (log_core[j] == 0) n0++;
    check("t6_no_core0", 128'(n0), 128'd0);
    check("t6_count", 128'(log_msg.size()), 128'd4);
    check("t6_exh", 128'(exhausted), 128'd1);
    check_order("t6_order", 12);
    dis = 2'b00;

    // Randomized searches against the index->message model
    lat_lo = 3;
    lat_hi = 8;
    for (int it = 0; it < 12; it++) begin
      s    = int'($urandom_range(15, 0));
      mode = int'($urandom_range(1, 0));
      k    = int'($urandom_range(15, s));
      dis  = ($urandom_range(3, 0) == 0) ? 2'b01 : 2'b00;
      exp_msg = msg_of(k);
      launch(4'(s), mode ? stub(exp_msg) : NO_HIT);
      wait_done("rnd");
      check_order("rnd_order", s);
      if (mode) begin
        check("rnd_found", 128'({found, exhausted}), 128'd2);
        check("rnd_found_msg", 128'(found_msg), 128'(exp_msg));
        check("rnd_found_core", 128'(found_core), 128'(core_of(exp_msg)));
        check("rnd_min_count", 128'(log_msg.size() >= k - s + 1), 128'd1);
      end else begin
        check("rnd_exh", 128'({found, exhausted, busy}), 128'd2);
        check("rnd_count", 128'(log_msg.size()), 128'(16 - s));
      end
      if (dis[0]) begin
        n0 = 0;
        foreach (log_core[j]) if (log_core[j] == 0) n0++;
        check("rnd_no_core0", 128'(n0), 128'd0);
      end
    end
    dis = 2'b00;

    check("protocol", 128'(proto_err), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
